// File: rtl/wf_starvation_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wf_starvation_arbiter_pkg
// Shared issue-stage definitions used by the wavefront arbiter slice:
//   WF_PER_CU        number of wavefront slots per compute unit
//   WF_ID_LENGTH     width of a wavefront id
//   ARB_STARVE_LIMIT default wait limit before a ready wavefront is forced
//   ARB_CNT_W        default width of the per-wavefront wait counter
// Optional feature macro (used by the top): ARB_STARVATION_GUARD_EN
// -----------------------------------------------------------------------------
package wf_starvation_arbiter_pkg;

    localparam int WF_PER_CU        = 40;
    localparam int WF_ID_LENGTH     = 6;
    localparam int ARB_STARVE_LIMIT = 15;
    localparam int ARB_CNT_W        = 4;

endpackage

// File: rtl/wf_starvation_arbiter_rr_priority_encoder.sv
// -----------------------------------------------------------------------------
// rr_priority_encoder
// Circular find-first-set: returns the first set request at or after start_i,
// scanning start_i, start_i+1, ..., NUM_WF-1, 0, ..., start_i-1.
// Ports:
//   req_i    NUM_WF request vector
//   start_i  scan start index (0..NUM_WF-1)
//   found_o  at least one request is set
//   idx_o    winning index, 0 when nothing is found
// -----------------------------------------------------------------------------
module rr_priority_encoder
    import wf_starvation_arbiter_pkg::*;
#(
    parameter int NUM_WF = WF_PER_CU,
    parameter int ID_W   = WF_ID_LENGTH
) (
    input  logic [NUM_WF-1:0] req_i,
    input  logic [ID_W-1:0]   start_i,
    output logic              found_o,
    output logic [ID_W-1:0]   idx_o
);

    logic [2*NUM_WF-1:0] doubledReq;
    logic [2*NUM_WF-1:0] shiftedReq;
    logic [NUM_WF-1:0]   rotatedReq;
    logic [ID_W-1:0]     firstOffset;
    logic [ID_W:0]       unrotatedSum;

    // Rotate so that start_i lands on bit 0. Shifting a doubled copy avoids
    // a variable bit-select and handles the circular wrap for free.
    always_comb begin
        doubledReq = {req_i, req_i};
        shiftedReq = doubledReq >> start_i;
        rotatedReq = shiftedReq[NUM_WF-1:0];
    end

    // Plain find-first-set on the rotated vector.
    always_comb begin
        found_o     = 1'b0;
        firstOffset = '0;
        for (int j = 0; j < NUM_WF; j++) begin
            if (rotatedReq[j] && !found_o) begin
                found_o     = 1'b1;
                firstOffset = ID_W'(j);
            end
        end
    end

    // Un-rotate with a mod-NUM_WF add; NUM_WF is not a power of two, so a
    // single conditional subtract is used instead of dropping the carry.
    always_comb begin
        unrotatedSum = {1'b0, start_i} + {1'b0, firstOffset};
        if (unrotatedSum >= (ID_W+1)'(NUM_WF)) begin
            unrotatedSum = unrotatedSum - (ID_W+1)'(NUM_WF);
        end
        idx_o = found_o ? unrotatedSum[ID_W-1:0] : '0;
    end

endmodule

// File: rtl/wf_starvation_arbiter.sv
// -----------------------------------------------------------------------------
// wf_starvation_arbiter
// Round-robin wavefront arbiter for one issue class. Picks one ready wavefront
// per cycle; the rotating pointer moves past whichever wavefront the issue
// logic reports as issued (from any class), so all class arbiters rotate
// together. With ARB_STARVATION_GUARD_EN defined, a per-wavefront wait counter
// forces the lowest-index wavefront that has waited STARVE_LIMIT cycles.
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   input_arry     per-wavefront ready vector for this class
//   issued_en      a wavefront was issued this cycle
//   issued_wf_id   id of the issued wavefront (ids >= NUM_WF are ignored)
//   choosen_valid  some wavefront is selected
//   choosen_wf_id  selected wavefront id (0 when nothing is selected)
// Optional feature macro: ARB_STARVATION_GUARD_EN
// -----------------------------------------------------------------------------
module wf_starvation_arbiter
    import wf_starvation_arbiter_pkg::*;
#(
    parameter int NUM_WF       = WF_PER_CU,
    parameter int ID_W         = WF_ID_LENGTH,
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT,
    parameter int CNT_W        = ARB_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_WF-1:0] input_arry,
    input  logic              issued_en,
    input  logic [ID_W-1:0]   issued_wf_id,
    output logic              choosen_valid,
    output logic [ID_W-1:0]   choosen_wf_id
);

    // The wait counter must be able to hold the limit value.
    if (STARVE_LIMIT >= (1 << CNT_W)) begin : gBadCntWidth
        $error("wf_starvation_arbiter: STARVE_LIMIT does not fit in CNT_W bits");
    end

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic            issueValid;
    logic            rrFound;
    logic [ID_W-1:0] rrIdx;
    logic            selFound;
    logic [ID_W-1:0] selIdx;

    // Issue feedback only counts for ids that name a real wavefront slot.
    assign issueValid = issued_en && ({1'b0, issued_wf_id} < (ID_W+1)'(NUM_WF));

    // Pointer moves just past the issued wavefront, wrapping after the last slot.
    always_comb begin
        ptr_d = ptr_q;
        if (issueValid) begin
            if (issued_wf_id == ID_W'(NUM_WF - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = issued_wf_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    rr_priority_encoder #(
        .NUM_WF (NUM_WF),
        .ID_W   (ID_W)
    ) uRrEnc (
        .req_i   (input_arry),
        .start_i (ptr_q),
        .found_o (rrFound),
        .idx_o   (rrIdx)
    );

`ifdef ARB_STARVATION_GUARD_EN
    logic [CNT_W-1:0]  waitCnt_q [NUM_WF];
    logic [CNT_W-1:0]  waitCnt_d [NUM_WF];
    logic [NUM_WF-1:0] starved;
    logic              starveFound;
    logic [ID_W-1:0]   starveIdx;

    // Issue clears first, then an idle slot clears, otherwise count up and
    // hold at the limit so the wavefront stays forced until it is issued.
    always_comb begin
        for (int i = 0; i < NUM_WF; i++) begin
            waitCnt_d[i] = waitCnt_q[i];
            if (issueValid && (issued_wf_id == ID_W'(i))) begin
                waitCnt_d[i] = '0;
            end else if (!input_arry[i]) begin
                waitCnt_d[i] = '0;
            end else if (waitCnt_q[i] != CNT_W'(STARVE_LIMIT)) begin
                waitCnt_d[i] = waitCnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_WF; i++) begin
            if (rst) begin
                waitCnt_q[i] <= '0;
            end else begin
                waitCnt_q[i] <= waitCnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_WF; i++) begin
            starved[i] = input_arry[i] && (waitCnt_q[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    // Same encoder with a fixed start of 0 gives the lowest-index starved slot.
    rr_priority_encoder #(
        .NUM_WF (NUM_WF),
        .ID_W   (ID_W)
    ) uStarveEnc (
        .req_i   (starved),
        .start_i ('0),
        .found_o (starveFound),
        .idx_o   (starveIdx)
    );

    always_comb begin
        selFound = rrFound;
        selIdx   = starveFound ? starveIdx : rrIdx;
    end
`else
    always_comb begin
        selFound = rrFound;
        selIdx   = rrIdx;
    end
`endif

    // Reset forces the outputs low in the same cycle it is asserted.
    always_comb begin
        choosen_valid = 1'b0;
        choosen_wf_id = '0;
        if (!rst) begin
            choosen_valid = selFound;
            choosen_wf_id = selIdx;
        end
    end

endmodule

// File: tb/tb_wf_starvation_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wf_starvation_arbiter
// Directed bench for wf_starvation_arbiter with an abstract reference model.
// Honours ARB_STARVATION_GUARD_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_wf_starvation_arbiter;

    localparam int N     = 40;
    localparam int IDW   = 6;
    localparam int LIMIT = 15;

    logic           clk;
    logic           rst;
    logic [N-1:0]   inputArry;
    logic           issuedEn;
    logic [IDW-1:0] issuedWfId;
    logic           choosenValid;
    logic [IDW-1:0] choosenWfId;

    int checks = 0;
    int errors = 0;
    bit compareOn = 0;

    int mPtr;
    int mCnt [N];

    wf_starvation_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .input_arry    (inputArry),
        .issued_en     (issuedEn),
        .issued_wf_id  (issuedWfId),
        .choosen_valid (choosenValid),
        .choosen_wf_id (choosenWfId)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state advances on each rising edge from the spec rules.
    always @(posedge clk) begin
        if (rst) begin
            mPtr = 0;
            for (int i = 0; i < N; i++) mCnt[i] = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (issuedEn && int'(issuedWfId) == i) mCnt[i] = 0;
                else if (!inputArry[i]) mCnt[i] = 0;
                else if (mCnt[i] < LIMIT) mCnt[i] = mCnt[i] + 1;
            end
            if (issuedEn && int'(issuedWfId) < N) mPtr = (int'(issuedWfId) + 1) % N;
        end
    end

    // Expected selection computed from the current model state and inputs.
    function automatic void modelSelect(output bit expValid, output int expId);
        expValid = 0;
        expId    = 0;
        if (!rst && (inputArry != '0)) begin
            expValid = 1;
            for (int k = 0; k < N; k++) begin
                if (inputArry[(mPtr + k) % N]) begin
                    expId = (mPtr + k) % N;
                    break;
                end
            end
`ifdef ARB_STARVATION_GUARD_EN
            for (int i = 0; i < N; i++) begin
                if (inputArry[i] && mCnt[i] == LIMIT) begin
                    expId = i;
                    break;
                end
            end
`endif
        end
    endfunction

    // Continuous comparison against the model every cycle.
    always @(negedge clk) begin
        bit expValid;
        int expId;
        if (compareOn) begin
            modelSelect(expValid, expId);
            checks = checks + 1;
            if (choosenValid !== expValid || int'(choosenWfId) !== expId) begin
                errors = errors + 1;
                $display("[TB] FAIL model_cmp t=%0t: got valid=%0b id=%0d, expected valid=%0b id=%0d",
                         $time, choosenValid, choosenWfId, expValid, expId);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic [N-1:0] arr,
                                 input logic en, input logic [IDW-1:0] id);
        rst        = r;
        inputArry  = arr;
        issuedEn   = en;
        issuedWfId = id;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed literal expectation, checked mid-cycle.
    task automatic checkOutput(input string name, input logic expValid, input int expId);
        @(negedge clk);
        #1;
        checks = checks + 1;
        if (choosenValid !== expValid || int'(choosenWfId) !== expId) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got valid=%0b id=%0d, expected valid=%0b id=%0d",
                     name, choosenValid, choosenWfId, expValid, expId);
        end
    endtask

    function automatic logic [N-1:0] bits2(input int a, input int b);
        logic [N-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        v[b] = 1'b1;
        return v;
    endfunction

    initial begin
        applyStimulus(1'b1, '0, 1'b0, '0);
        compareOn = 1;
        stepCycle();
        checkOutput("reset_idle", 1'b0, 0);
        stepCycle();

        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("empty_after_reset", 1'b0, 0);
        stepCycle();

        // ptr=0, bits 5 and 12; issue 5 -> next 12
        applyStimulus(1'b0, bits2(5, 12), 1'b1, 6'd5);
        checkOutput("rr_first_5", 1'b1, 5);
        stepCycle();
        applyStimulus(1'b0, bits2(5, 12), 1'b0, '0);
        checkOutput("rr_after_issue_12", 1'b1, 12);
        stepCycle();

        // ptr=6, bits 3 and 39; issue 39 -> wrap to 0 -> 3
        applyStimulus(1'b0, bits2(3, 39), 1'b1, 6'd39);
        checkOutput("rr_pre_wrap_39", 1'b1, 39);
        stepCycle();
        applyStimulus(1'b0, bits2(3, 39), 1'b0, '0);
        checkOutput("rr_wrap_3", 1'b1, 3);
        stepCycle();

        // Move ptr to 7, then out-of-range ids must be ignored
        applyStimulus(1'b0, '0, 1'b1, 6'd6);
        stepCycle();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, bits2(2, 8), 1'b1, 6'd45);
            checkOutput("ignore_id45", 1'b1, 8);
            stepCycle();
        end

        // Idle cycle clears all wait counters
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("idle_clear", 1'b0, 0);
        stepCycle();

        // Starvation scenario: bits 2 and 10, id 9 issued each cycle
        for (int c = 0; c < 20; c++) begin
            int expId;
            applyStimulus(1'b0, bits2(2, 10), 1'b1, (c == 16) ? 6'd2 : 6'd9);
`ifdef ARB_STARVATION_GUARD_EN
            expId = (c == 15 || c == 16) ? 2 : 10;
`else
            expId = 10;
`endif
            checkOutput($sformatf("starve_c%0d", c), 1'b1, expId);
            stepCycle();
        end

        // Mid-run reset with ptr=25, bits 20 and 30
        applyStimulus(1'b0, '0, 1'b1, 6'd24);
        stepCycle();
        applyStimulus(1'b0, bits2(20, 30), 1'b0, '0);
        checkOutput("pre_reset_30", 1'b1, 30);
        stepCycle();
        applyStimulus(1'b1, bits2(20, 30), 1'b0, '0);
        checkOutput("in_reset_zero", 1'b0, 0);
        stepCycle();
        applyStimulus(1'b0, bits2(20, 30), 1'b0, '0);
        checkOutput("post_reset_20", 1'b1, 20);
        for (int c = 0; c < 5; c++) stepCycle();

        compareOn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
